// File: rtl/mlp_pkg.sv
// mlp_pkg: Q16.16 fixed-point types, constants, saturating helpers and FSM states.
package mlp_pkg;
  typedef logic signed [31:0] fix_t;
  localparam fix_t ONE = 32'h0001_0000;
  localparam fix_t HALF = 32'h0000_8000;
  typedef enum logic [3:0] {IDLE, LOAD, HMAC, HACT, OMAC, OACT, EMIT, OERR, HERR, UPD} state_t;
  function automatic fix_t fx_mul(input fix_t a, input fix_t b);
    logic [63:0] p;
    p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    return (p[63:47] == {17{p[63]}}) ? fix_t'(p[47:16]) :
           (p[63] ? fix_t'(32'h8000_0000) : fix_t'(32'h7FFF_FFFF));
  endfunction
  function automatic fix_t fx_sat_add(input fix_t a, input fix_t b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    return (s[32] != s[31]) ? (s[32] ? fix_t'(32'h8000_0000) : fix_t'(32'h7FFF_FFFF)) :
           fix_t'(s[31:0]);
  endfunction
endpackage

// File: rtl/mlp_seq_engine_if.sv
// mlp_seq_engine_if: sample input and result output valid/ready streams.
interface mlp_seq_engine_if;
  import mlp_pkg::*;
  logic in_valid, in_ready, in_train, out_valid, out_ready;
  fix_t in_data, out_data;
  modport master (output in_valid, in_data, in_train, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, in_train, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/sigmoid_hard.sv
// sigmoid_hard: piecewise-linear sigmoid clamp(x/4 + 0.5, 0, 1) in Q16.16.
module sigmoid_hard
  import mlp_pkg::*;
(
  input fix_t x,
  output fix_t y
);
  fix_t q;
  assign q = (x >>> 2) + HALF;
  assign y = q[31] ? '0 : (q > ONE ? ONE : q);
endmodule

// File: rtl/mlp_seq_engine.sv
// mlp_seq_engine: time-multiplexed one-hidden-layer MLP with inference and backprop training.
module mlp_seq_engine
  import mlp_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int N_HID = 4,
  parameter fix_t LR = 32'h0000_4000,
  parameter fix_t INIT_W = 32'h0000_3800,
  localparam int NW = N_IN * N_HID + N_HID,
  localparam int AW = $clog2(NW)
)(
  input logic clk,
  input logic rst,
  mlp_seq_engine_if.slave bus,
  output logic busy,
  input logic wclr,
  input logic [AW-1:0] w_addr,
  output fix_t w_data
);
  localparam int KW = N_HID > 1 ? $clog2(N_HID) : 1;
  localparam int XW = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam int JW = $clog2(N_IN + 1);
  state_t state, nxt;
  fix_t wt[NW];
  fix_t x[N_IN];
  fix_t acc[N_HID], h[N_HID], dh[N_HID];
  fix_t t, s, y, dlo, a, b, c, d, r, sig_in, sig, xj, hk, wk, wok;
  logic train, adv, kl, last_word;
  logic [KW-1:0] k;
  logic [JW-1:0] j, jmax;
  logic [AW-1:0] wi, woi;
  assign xj = x[j[XW-1:0]];
  assign hk = h[k];
  assign wi = AW'(k) * AW'(N_IN) + AW'(j);
  assign woi = AW'(N_IN * N_HID) + AW'(k);
  assign wk = wt[wi];
  assign wok = wt[woi];
  assign kl = k == KW'(N_HID - 1);
  assign last_word = j == JW'(train ? N_IN : N_IN - 1);
  assign sig_in = state == OACT ? s : acc[k];
  assign r = fx_mul(fx_mul(a, b), fx_mul(c, d));
  sigmoid_hard u_sig (.x(sig_in), .y(sig));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    bus.in_ready = state == IDLE || state == LOAD;
    bus.out_valid = state == EMIT;
    bus.out_data = y;
    busy = state != IDLE;
    case (state)
      IDLE: if (bus.in_valid) nxt = (N_IN == 1 && !bus.in_train) ? HMAC : LOAD;
      LOAD: if (bus.in_valid && last_word) nxt = HMAC;
      HMAC: if (kl && j == JW'(N_IN - 1)) nxt = HACT;
      HACT: if (kl) nxt = OMAC;
      OMAC: if (kl) nxt = OACT;
      OACT: nxt = EMIT;
      EMIT: if (bus.out_ready) nxt = train ? OERR : IDLE;
      OERR: nxt = HERR;
      HERR: if (kl) nxt = UPD;
      UPD: if (kl && j == JW'(N_IN)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // One multiply chain r = (a*b)*(c*d); c=d=ONE reduces it to a plain MAC product.
  always_comb begin
    a = '0;
    b = '0;
    c = ONE;
    d = ONE;
    adv = state inside {HMAC, HACT, OMAC, HERR, UPD} || (state == LOAD && bus.in_valid);
    jmax = state == HMAC ? JW'(N_IN - 1) : (state inside {LOAD, UPD} ? JW'(N_IN) : '0);
    case (state)
      HMAC: begin a = wk; b = xj; end
      OMAC: begin a = wok; b = hk; end
      OERR: begin a = fx_sat_add(t, -y); b = ONE - y; c = y; end
      HERR: begin a = dlo; b = wok; c = hk; d = ONE - hk; end
      UPD: begin a = LR; b = j == JW'(N_IN) ? dlo : dh[k]; c = j == JW'(N_IN) ? hk : xj; end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NW; i++) wt[i] <= INIT_W;
      for (int i = 0; i < N_IN; i++) x[i] <= '0;
      for (int i = 0; i < N_HID; i++) begin acc[i] <= '0; h[i] <= '0; dh[i] <= '0; end
      {t, s, y, dlo, w_data} <= '0;
      train <= 1'b0;
      k <= '0;
      j <= '0;
    end else begin
      w_data <= 32'(w_addr) < NW ? wt[w_addr] : '0;
      if (state != nxt) begin
        k <= '0;
        j <= state == IDLE ? JW'(1) : '0;
      end else if (adv) begin
        if (j == jmax) begin j <= '0; k <= k + 1'b1; end
        else j <= j + 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.in_valid) begin x[0] <= bus.in_data; train <= bus.in_train; end
          if (wclr) for (int i = 0; i < NW; i++) wt[i] <= INIT_W;
        end
        LOAD: if (bus.in_valid) begin
          if (j == JW'(N_IN)) t <= bus.in_data;
          else x[j[XW-1:0]] <= bus.in_data;
        end
        HMAC: acc[k] <= fx_sat_add(j == '0 ? fix_t'(0) : acc[k], r);
        HACT: h[k] <= sig;
        OMAC: s <= fx_sat_add(k == '0 ? fix_t'(0) : s, r);
        OACT: y <= sig;
        OERR: dlo <= r;
        HERR: dh[k] <= r;
        UPD: if (j == JW'(N_IN)) wt[woi] <= fx_sat_add(wok, r);
             else wt[wi] <= fx_sat_add(wk, r);
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mlp_seq_engine.sv
// tb_mlp_seq_engine: directed vectors and corner sequences for mlp_seq_engine at default parameters.
module tb_mlp_seq_engine;
  import mlp_pkg::*;
  typedef struct {
    string name;
    logic [3:0][31:0] x;
    logic [31:0] y;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, wclr = 1'b0, busy;
  logic [4:0] w_addr = '0;
  fix_t w_data;
  int checks = 0, errors = 0;
  vec_t tv[6];
  mlp_seq_engine_if bus();
  mlp_seq_engine dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy), .wclr(wclr), .w_addr(w_addr), .w_data(w_data));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic put_word(input logic [31:0] v, input logic tr);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = v;
    bus.in_train = tr;
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("in_ready timeout", 32'(n), 0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic send(input logic [3:0][31:0] xs, input logic tr, input logic [31:0] tt);
    for (int i = 0; i < 4; i++) put_word(xs[i], tr);
    if (tr) put_word(tt, tr);
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus.out_valid && lat < 200);
  endtask
  task automatic take_out();
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask
  task automatic read_w(input int adr, output logic [31:0] v);
    @(negedge clk) w_addr = 5'(adr);
    @(posedge clk);
    #1 v = w_data;
  endtask
  task automatic run_infer(input string nm, input logic [3:0][31:0] xs, input logic [31:0] ey);
    int lat;
    send(xs, 1'b0, '0);
    wait_out(lat);
    chk({nm, " latency"}, 32'(lat), 25);
    chk({nm, " out_data"}, bus.out_data, ey);
    take_out();
  endtask
  task automatic run_train_zero();
    int lat;
    send('0, 1'b1, 32'h0001_0000);
    wait_out(lat);
    chk("train latency", 32'(lat), 25);
    chk("train out_data", bus.out_data, 32'h0000_9C00);
    take_out();
    lat = 0;
    while (busy && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("train return cycles", 32'(lat), 25);
  endtask
  initial begin
    logic [31:0] v;
    int lat;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_train = 1'b0;
    bus.out_ready = 1'b0;
    tv[0] = '{"zero", {4{32'h0}}, 32'h0000_9C00};
    tv[1] = '{"ones", {4{32'h0001_0000}}, 32'h0000_A840};
    tv[2] = '{"sat_pos", {4{32'h7FFF_FFFF}}, 32'h0000_B800};
    tv[3] = '{"single", {32'h0, 32'h0, 32'h0, 32'h0001_0000}, 32'h0000_9F10};
    tv[4] = '{"minus_one", {4{32'hFFFF_0000}}, 32'h0000_8FC0};
    tv[5] = '{"sat_neg", {4{32'h8000_0000}}, 32'h0000_8000};
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_data", bus.out_data, 0);
    chk("reset busy", busy, 0);
    chk("reset w_data", w_data, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 6; i++) run_infer(tv[i].name, tv[i].x, tv[i].y);
    read_w(0, v);
    chk("infer keeps w", v, 32'h0000_3800);
    read_w(19, v);
    chk("infer keeps wo", v, 32'h0000_3800);
    run_train_zero();
    for (int i = 0; i < 20; i++) begin
      read_w(i, v);
      chk($sformatf("trained w%0d", i), v, i < 16 ? 32'h0000_3800 : 32'h0000_3AF9);
    end
    send('0, 1'b0, '0);
    wait_out(lat);
    chk("stall latency", 32'(lat), 25);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = 32'hDEAD_BEEF;
      wclr = 1'b1;
      #1;
      chk("stall out_valid", bus.out_valid, 1);
      chk("stall out_data", bus.out_data, 32'h0000_9D7C);
      chk("stall in_ready", bus.in_ready, 0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    wclr = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("after stall busy", busy, 0);
    read_w(16, v);
    chk("wclr busy ignored", v, 32'h0000_3AF9);
    send({4{32'h0001_0000}}, 1'b0, '0);
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst in_ready", bus.in_ready, 1);
    chk("midrst out_valid", bus.out_valid, 0);
    chk("midrst out_data", bus.out_data, 0);
    chk("midrst w_data", w_data, 0);
    @(negedge clk) rst = 1'b0;
    read_w(16, v);
    chk("midrst wo restored", v, 32'h0000_3800);
    run_infer("post_rst", {4{32'h0001_0000}}, 32'h0000_A840);
    run_train_zero();
    @(negedge clk) wclr = 1'b1;
    @(posedge clk);
    #1 wclr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      read_w(i, v);
      chk($sformatf("wclr w%0d", i), v, 32'h0000_3800);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
